// File: rtl/prog_clock_divider.sv
// prog_clock_divider
//   Runtime-programmable integer clock divider. Any divisor from 2 to
//   2^WIDTH-1 yields a near-50%-duty clk_out (high ceil(D/2), low floor(D/2))
//   and a one-cycle tick at the start of each output period. Divisor writes
//   are held pending and applied only at a period boundary, so clk_out never
//   produces a runt pulse. Everything runs on clk; clk_out is a data output.
//
//   Build option: define DIV_TAPS_EN to build the power-of-two tap counter
//   that drives taps[]. Without it, taps is tied to zero.

module prog_clock_divider #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2,
  parameter int TAP_BITS  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [WIDTH-1:0]    div_val,
  input  logic                div_wr,
  output logic                div_busy,
  output logic                clk_out,
  output logic                tick,
  output logic [TAP_BITS-1:0] taps
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] div_pend;
  logic             pend_valid;

  logic             wrap;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] div_next;
  logic [WIDTH:0]   half_next;
  logic             clk_out_next;
  logic [WIDTH-1:0] div_clamped;

  // Next-state: period counter, divisor hand-over at the wrap, output level.
  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wrap         = 1'b0;
    cnt_next     = cnt;
    div_next     = div_act;
    half_next    = '0;
    clk_out_next = 1'b0;
    div_clamped  = div_val;

    wrap = (cnt == div_act - WIDTH'(1));
    if (wrap) begin
      cnt_next = '0;
      if (pend_valid) div_next = div_pend;
    end else begin
      cnt_next = cnt + WIDTH'(1);
    end

    // One extra bit so D = 2^WIDTH-1 does not overflow when rounding up.
    half_next    = ({1'b0, div_next} + (WIDTH+1)'(1)) >> 1;
    clk_out_next = ({1'b0, cnt_next} < half_next);

    // Divisors below 2 cannot form a period; treat them as 2.
    if (div_val < WIDTH'(2)) div_clamped = WIDTH'(2);
  end

  // Period counter, active divisor and registered clk_out/tick.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= WIDTH'(RESET_DIV - 1);
      div_act <= WIDTH'(RESET_DIV);
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (en) begin
      cnt     <= cnt_next;
      div_act <= div_next;
      clk_out <= clk_out_next;
      tick    <= wrap;
    end else begin
      tick    <= 1'b0;
    end
  end

  // Pending divisor: a write always wins over the wrap consuming the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_pend   <= WIDTH'(RESET_DIV);
      pend_valid <= 1'b0;
    end else if (div_wr) begin
      div_pend   <= div_clamped;
      pend_valid <= 1'b1;
    end else if (en && wrap && pend_valid) begin
      pend_valid <= 1'b0;
    end
  end

  assign div_busy = pend_valid;

`ifdef DIV_TAPS_EN
  logic [TAP_BITS-1:0] tap_cnt;

  // Synchronous tap counter: advances on the edge that raises tick, so every
  // tap changes together with tick and the rising edge of clk_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_cnt <= '0;
    end else if (en && wrap) begin
      tap_cnt <= tap_cnt + TAP_BITS'(1);
    end
  end

  assign taps = tap_cnt;
`else
  assign taps = '0;
`endif

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
- Synchronous, runtime-programmable integer clock divider. Generalises the fixed divide-by-2^n chain to any divisor from 2 to 2^WIDTH-1.
- Produces a near-50%-duty divided clock and a one-cycle tick strobe. Optionally produces a binary tap chain that further divides the output by powers of two.
- Every flop is clocked by clk; no derived clocks exist inside the block. Sits between the tile clock and downstream blinkers, PWM and test outputs.

Parameters:
- WIDTH, 8, width of the divisor and the period counter.
- RESET_DIV, 2, divisor in effect after reset; legal range 2..2^WIDTH-1.
- TAP_BITS, 7, number of power-of-two tap outputs (only used when DIV_TAPS_EN is defined).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- en  in  1  count enable; when low, all state holds.
- div_val  in  WIDTH  new divisor value.
- div_wr  in  1  one-cycle strobe; captures div_val into the pending register.
- div_busy  out  1  high while a pending divisor is waiting to be applied.
- clk_out  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse at the start of each output period, registered.
- taps  out  TAP_BITS  taps[i] = clk_out frequency / 2^(i+1), registered.

Behaviour:
- Reset (synchronous, priority over all else). After the reset edge:
  - cnt = RESET_DIV-1, div_act = RESET_DIV.
  - pend_valid = 0; any pending divisor is discarded.
  - clk_out = 0, tick = 0, taps = 0, div_busy = 0.
  - Reset asserted mid-operation gives exactly these values on the next edge.
- Divisor in effect, D = div_act. Half-period H = (D+1)>>1, computed WIDTH+1 bits wide so that D = 2^WIDTH-1 does not overflow.
- On each clock edge with en=1:
  - Wrap (cnt == D-1): cnt <= 0. If pend_valid, then div_act <= div_pend and pend_valid <= 0.
  - Otherwise: cnt <= cnt+1.
  - tick <= (cnt == D-1).
  - clk_out <= (cnt_next < H_next), where H_next uses the divisor in effect after the edge.
  - Result: clk_out is high for ceil(D/2) cycles and low for floor(D/2) cycles. It rises in the same cycle tick is high, and is glitch-free.
- First enabled edge after reset always wraps. tick and clk_out both rise 1 cycle after en is first seen high, so there is no truncated first period.
- With en=0: cnt, clk_out, div_act and taps hold; tick = 0. Divisor writes are still accepted.
- Divisor writes (div_wr=1):
  - div_pend <= clamp(div_val), where div_val < 2 is stored as 2; pend_valid <= 1.
  - Multiple writes before a wrap: the last write wins.
  - Write in the same cycle as a wrap: the wrap applies the previously pending value (if any). The new value stays pending and is applied at the next wrap.
  - div_busy = pend_valid, registered.
- Divisor changes take effect only at a period boundary, so clk_out never produces a runt pulse.
- Tap chain: a TAP_BITS-wide binary counter increments on each cycle where tick=1 and wraps at all-ones to 0; taps = counter bits. The counter is synchronous, not rippled, so all taps change on the same clk edge.

Optional Feature:
- Macro: DIV_TAPS_EN.
- Defined: the tap counter is built as described above.
- Undefined: no tap counter is built; taps is tied to 0; the TAP_BITS parameter is still accepted.
- clk_out, tick and div_busy behave identically in both builds.

Test Plan:
- Reset, then en=1 with RESET_DIV=4 -> tick high on cycles 1, 5, 9; clk_out pattern 1,1,0,0 repeating from cycle 1.
- div_wr with div_val=5 while idle, then en=1 -> div_busy=1 until the first wrap, then 0; clk_out high 3 cycles, low 2 cycles; tick every 5 cycles.
- Running at D=4, div_wr div_val=3 at cnt=1 -> current 4-cycle period completes, next periods are 3 cycles (high 2, low 1). Repeat with div_wr coincident with the wrap -> one more 4-cycle period, then 3.
- div_val=0 and div_val=1 -> clamped to D=2: clk_out toggles every cycle, tick every 2 cycles. Also D=255 -> high 128 cycles, low 127.
- en dropped for 7 cycles mid-period at D=6 -> clk_out and cnt frozen, tick=0 throughout; period resumes with the remaining cycles only. rst pulsed mid-period -> all outputs at reset values the next cycle, pending divisor discarded.
- DIV_TAPS_EN defined, D=2 -> taps[0] period 4 cycles, taps[1] period 8 cycles, taps[6] period 256 cycles, all edges aligned to tick. Undefined -> taps == 0 always.
